// File: rtl/iter_divider.sv
// Purpose : radix-2 restoring divider, signed or unsigned, quotient + remainder.
// Latency : WIDTH cycles from the acceptance edge to a one-cycle data_ok pulse.
// Backpr. : the requester holds valid until data_ok; one op in flight, flush aborts it.
//
// Ports:
//   clk, resetn        clock, async active-low reset
//   valid, is_signed   request level and signedness, sampled only at acceptance
//   srca, srcb         dividend, divisor, sampled only at acceptance
//   flush              abort the in-flight op; no data_ok, outputs keep their values
//   result, rem        registered quotient and remainder
//   data_ok            completion pulse (DONE state)
//   busy               high in BUSY and DONE
module iter_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             data_ok,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dvd_q;     // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] prem_q;    // partial remainder
    logic [WIDTH-1:0] dvs_q;     // divisor magnitude
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic             neg_q_d, neg_r_d;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prem_nx, dvd_nx;
    logic             last_iter;

    // Operand magnitudes. -2^(W-1) maps onto itself, which is the correct
    // unsigned magnitude 2^(W-1), so no overflow special case is needed.
    always_comb begin
        abs_a   = (is_signed && srca[WIDTH-1]) ? -srca : srca;
        abs_b   = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;
        neg_r_d = is_signed & srca[WIDTH-1];
        // A zero divisor yields an all-ones quotient; forcing the quotient sign
        // positive keeps it all ones for signed requests as well.
        neg_q_d = is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]) & (|srcb);
    end

    // One restoring step. The shifted remainder needs WIDTH+1 bits; when it is
    // >= divisor the difference is < divisor, so WIDTH bits of it are exact.
    always_comb begin
        shifted   = {prem_q, dvd_q[WIDTH-1]};
        ge        = (shifted >= {1'b0, dvs_q});
        diff      = shifted[WIDTH-1:0] - dvs_q;
        prem_nx   = ge ? diff : shifted[WIDTH-1:0];
        dvd_nx    = {dvd_q[WIDTH-2:0], ge};
        last_iter = (count_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (valid) state_d = S_BUSY;
            S_BUSY:  if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q  <= '0;
            dvd_q    <= '0;
            prem_q   <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
        end else if (!flush) begin
            if (state_q == S_IDLE && valid) begin
                dvd_q   <= abs_a;
                dvs_q   <= abs_b;
                prem_q  <= '0;
                count_q <= '0;
                neg_q_q <= neg_q_d;
                neg_r_q <= neg_r_d;
            end else if (state_q == S_BUSY) begin
                dvd_q   <= dvd_nx;
                prem_q  <= prem_nx;
                count_q <= count_q + CW'(1);
                if (last_iter) begin
                    result_q <= neg_q_q ? -dvd_nx : dvd_nx;
                    rem_q    <= neg_r_q ? -prem_nx : prem_nx;
                end
            end
        end
    end

    assign result  = result_q;
    assign rem     = rem_q;
    assign data_ok = (state_q == S_DONE);
    assign busy    = (state_q != S_IDLE);

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider. It is the responder side of the execute-stage valid/data_ok handshake.
- The ALU drives a level `valid` and stalls the pipe (bubble = ~data_ok) until this block pulses `data_ok` with quotient and remainder.
- One instance serves both signed (DIV/REM) and unsigned (DIVU/REMU) requests, selected by `is_signed`.

Parameters:
- WIDTH, 64, operand/result width in bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  reset, asynchronous, active-low
- valid  input  1  request level, held by the requester until data_ok
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned
- srca  input  WIDTH  dividend
- srcb  input  WIDTH  divisor
- flush  input  1  abort any in-flight operation
- result  output  WIDTH  quotient, registered
- rem  output  WIDTH  remainder, registered
- data_ok  output  1  one-cycle completion pulse; result/rem valid while high
- busy  output  1  high in BUSY and DONE

Behaviour:
- Reset (resetn=0, async): state=IDLE, count=0, result=0, rem=0, data_ok=0, busy=0. This applies mid-operation too: the in-flight op is discarded and no data_ok is issued.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY at a rising edge where valid=1 and flush=0. On that edge:
  - latch is_signed, neg_q = srca[W-1]^srcb[W-1], neg_r = srca[W-1] (signed only, else both 0);
  - load |srca| into the dividend shift register and |srcb| into the divisor register;
  - clear partial remainder; count=0.
- Operands are sampled only at acceptance. Changes on srca/srcb/is_signed while BUSY or DONE are ignored.
- BUSY iteration, one per edge:
  - shift {partial_rem, dividend} left by 1;
  - trial = partial_rem_shifted - divisor, computed in WIDTH+1 bits;
  - if trial >= 0: partial_rem = trial and quotient LSB = 1; else quotient LSB = 0;
  - count++.
- When count reaches WIDTH-1 and that iteration completes, the edge moves BUSY -> DONE and writes:
  - result = neg_q ? -q : q;
  - rem = neg_r ? -r : r.
- DONE: data_ok=1 and busy=1, driven combinationally from state. The next edge always moves DONE -> IDLE, regardless of valid. data_ok is therefore exactly one cycle wide.
- Latency: acceptance edge E0; data_ok high in the cycle following edge E(WIDTH), i.e. 64 cycles after E0.
- Back-to-back ops: valid high in the cycle after DONE (IDLE) starts a new op at that edge. The minimum issue interval is WIDTH+2 cycles.
- result/rem hold their last values in IDLE and BUSY; they change only on the BUSY->DONE edge.
- Divide by zero: the requester normally gates valid when srcb=0. If accepted anyway, the op completes with the normal latency, giving result = all ones and rem = srca. This falls out of the restoring algorithm with neg_q forced to 0 when srcb=0.
- Signed overflow (-2^(W-1) / -1): result = -2^(W-1), rem = 0. No special-casing; the magnitude path is (W+1)-bit safe.
- flush=1 at any edge: state -> IDLE, no data_ok, result/rem unchanged. flush has priority over acceptance and completion.
- valid dropping while BUSY does not abort the op; only flush or reset does.
- Invariant: data_ok is never high in two consecutive cycles.

Test Plan:
- Unsigned 100 / 7, is_signed=0, valid held -> data_ok one cycle, 64 cycles after acceptance; result=14, rem=2; busy low the following cycle.
- Signed -7 / 2 -> result=-3 (0xFFFF_FFFF_FFFF_FFFD), rem=-1. Signed 7 / -2 -> result=-3, rem=1.
- Signed 0x8000_0000_0000_0000 / -1 -> result=0x8000_0000_0000_0000, rem=0. Unsigned 5 / 0 forced accept -> result=0xFFFF_FFFF_FFFF_FFFF, rem=5.
- Operand change at cycle 10 of BUSY (srca 100 -> 999) -> result still 14, rem 2. Second op with valid high directly after data_ok -> accepted in the next IDLE cycle, correct independent result.
- flush at cycle 30 of BUSY -> IDLE next cycle, no data_ok pulse, result/rem keep previous values. resetn low at cycle 20 -> immediate IDLE, all outputs 0, no data_ok after release.
